// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS integer execution unit.
// Holds the datapath width and the ALUcon operation encoding (values 0-10;
// 11-15 are reserved and decode to a zero result with HI/LO held).
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_DIV  = 4'd5,
    OP_MULT = 4'd6,
    OP_SLL  = 4'd7,
    OP_XOR  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_divider.sv
// Combinational 32/32 divider, signed or unsigned; zero latency, no backpressure.
// Ports: i_dividend, i_divisor, i_unsign (1 = unsigned) -> o_quot, o_rem.
// Signed mode truncates toward zero; remainder carries the dividend's sign.
// Divide by zero returns quotient all-ones and remainder = dividend.
module alu_divider
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_dividend,
  input  logic [ALU_W-1:0] i_divisor,
  input  logic             i_unsign,
  output logic [ALU_W-1:0] o_quot,
  output logic [ALU_W-1:0] o_rem
);

  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_div_zero;
  logic [ALU_W-1:0] w_mag_a;
  logic [ALU_W-1:0] w_mag_b;
  logic [ALU_W-1:0] w_uquot;
  logic [ALU_W-1:0] w_urem;

  assign w_neg_a    = ~i_unsign & i_dividend[ALU_W-1];
  assign w_neg_b    = ~i_unsign & i_divisor[ALU_W-1];
  assign w_div_zero = (i_divisor == '0);

  // Divide magnitudes unsigned and restore signs afterwards. The most
  // negative dividend has magnitude 2^31, which still fits unsigned, so
  // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign w_mag_a = w_neg_a ? (~i_dividend + 1'b1) : i_dividend;
  // Substitute 1 for a zero divisor so the arithmetic never sees /0;
  // that result is discarded below anyway.
  assign w_mag_b = w_div_zero ? {{(ALU_W-1){1'b0}}, 1'b1}
                              : (w_neg_b ? (~i_divisor + 1'b1) : i_divisor);

  assign w_uquot = w_mag_a / w_mag_b;
  assign w_urem  = w_mag_a % w_mag_b;

  always_comb begin
    o_quot = w_uquot;
    o_rem  = w_urem;
    if (w_div_zero) begin
      o_quot = '1;
      o_rem  = i_dividend;
    end else begin
      if (w_neg_a ^ w_neg_b) o_quot = ~w_uquot + 1'b1;
      if (w_neg_a)           o_rem  = ~w_urem + 1'b1;
    end
  end

endmodule

// File: rtl/mips_alu.sv
// MIPS integer execution unit with HI/LO register pair.
// Latency: ALUoutput/eq/lt combinational; HI/LO load one clk edge after MULT/DIV.
// No handshake: a new operation is accepted every cycle, nothing stalls.
// Ports: clk, reset (sync, active-high, clears HI/LO), reg_read_a (A), alub (B),
//        ALUcon (op select), unsign -> eq, lt, ALUoutput, lo, hi.
// Build option: define ALU_DIV_EN to build the divider (ALUcon 5); without it
// ALUcon 5 behaves as a reserved code (zero result, HI/LO hold).
module mips_alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ALU_W-1:0] reg_read_a,
  input  logic [ALU_W-1:0] alub,
  input  logic [3:0]       ALUcon,
  input  logic             unsign,
  output logic             eq,
  output logic             lt,
  output logic [ALU_W-1:0] ALUoutput,
  output logic [ALU_W-1:0] lo,
  output logic [ALU_W-1:0] hi
);

  logic [ALU_W-1:0]   r_hi;
  logic [ALU_W-1:0]   r_lo;

  logic [2*ALU_W-1:0] w_ext_a;
  logic [2*ALU_W-1:0] w_ext_b;
  logic [2*ALU_W-1:0] w_prod;
  logic               w_shift_big;
  logic [4:0]         w_shamt;
  logic               w_sra_fill;
  logic [ALU_W-1:0]   w_sll;
  logic [ALU_W-1:0]   w_srl;
  logic [ALU_W-1:0]   w_sra;

  // Compare flags are valid for every ALUcon.
  assign eq = (reg_read_a == alub);
  assign lt = unsign ? (reg_read_a < alub)
                     : ($signed(reg_read_a) < $signed(alub));

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // the correct signed or unsigned full product.
  assign w_ext_a = {{ALU_W{~unsign & reg_read_a[ALU_W-1]}}, reg_read_a};
  assign w_ext_b = {{ALU_W{~unsign & alub[ALU_W-1]}}, alub};
  assign w_prod  = w_ext_a * w_ext_b;

  // The shift amount is all 32 bits of B: anything >= 32 shifts everything out.
  assign w_shift_big = |alub[ALU_W-1:5];
  assign w_shamt     = alub[4:0];
  assign w_sra_fill  = ~unsign & reg_read_a[ALU_W-1];
  assign w_sll       = w_shift_big ? '0 : (reg_read_a << w_shamt);
  assign w_srl       = w_shift_big ? '0 : (reg_read_a >> w_shamt);
  assign w_sra       = w_shift_big ? {ALU_W{w_sra_fill}}
                                   : (unsign ? (reg_read_a >> w_shamt)
                                             : $unsigned($signed(reg_read_a) >>> w_shamt));

`ifdef ALU_DIV_EN
  logic [ALU_W-1:0] w_quot;
  logic [ALU_W-1:0] w_rem;

  alu_divider u_divider (
    .i_dividend (reg_read_a),
    .i_divisor  (alub),
    .i_unsign   (unsign),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );
`endif

  // MULT/DIV (and reserved codes) report zero on the main result bus.
  always_comb begin
    ALUoutput = '0;
    case (ALUcon)
      OP_ADD:  ALUoutput = reg_read_a + alub;
      OP_SUB:  ALUoutput = reg_read_a - alub;
      OP_AND:  ALUoutput = reg_read_a & alub;
      OP_OR:   ALUoutput = reg_read_a | alub;
      OP_SLT:  ALUoutput = {{(ALU_W-1){1'b0}}, lt};
      OP_SLL:  ALUoutput = w_sll;
      OP_XOR:  ALUoutput = reg_read_a ^ alub;
      OP_SRL:  ALUoutput = w_srl;
      OP_SRA:  ALUoutput = w_sra;
      default: ALUoutput = '0;
    endcase
  end

  // Reset wins over a simultaneous MULT/DIV; other ops hold HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (ALUcon == OP_MULT) begin
      r_hi <= w_prod[2*ALU_W-1:ALU_W];
      r_lo <= w_prod[ALU_W-1:0];
    end
`ifdef ALU_DIV_EN
    else if (ALUcon == OP_DIV) begin
      r_hi <= w_rem;
      r_lo <= w_quot;
    end
`endif
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vectors plus randomized ops
// checked against an arithmetic reference model.
module tb_mips_alu;
  import alu_pkg::*;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        u;
  logic        eq, lt;
  logic [31:0] y, lo, hi;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mips_alu dut (
    .clk        (clk),
    .reset      (reset),
    .reg_read_a (a),
    .alub       (b),
    .ALUcon     (op),
    .unsign     (u),
    .eq         (eq),
    .lt         (lt),
    .ALUoutput  (y),
    .lo         (lo),
    .hi         (hi)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic ref_lt(input logic [31:0] xa, input logic [31:0] xb, input logic xu);
    int sa, sb;
    sa = xa;
    sb = xb;
    if (xu) return (xa < xb);
    return (sa < sb);
  endfunction

  function automatic logic [31:0] ref_out(input logic [31:0] xa, input logic [31:0] xb,
                                          input logic [3:0] xop, input logic xu);
    int sa;
    sa = xa;
    case (xop)
      4'd0:  return xa + xb;
      4'd1:  return xa - xb;
      4'd2:  return xa & xb;
      4'd3:  return xa | xb;
      4'd4:  return ref_lt(xa, xb, xu) ? 32'd1 : 32'd0;
      4'd7:  return (xb >= 32) ? 32'd0 : (xa << xb);
      4'd8:  return xa ^ xb;
      4'd9:  return (xb >= 32) ? 32'd0 : (xa >> xb);
      4'd10: begin
        if (xu) return (xb >= 32) ? 32'd0 : (xa >> xb);
        if (xb >= 32) return (sa < 0) ? 32'hFFFFFFFF : 32'd0;
        return sa >>> xb;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Returns the new {HI, LO} given the current pair.
  function automatic logic [63:0] ref_hilo(input logic [31:0] xa, input logic [31:0] xb,
                                           input logic [3:0] xop, input logic xu,
                                           input logic [63:0] cur);
    longint p;
    int     sa, sb, q, r;
    if (xop == 4'd6) begin
      if (xu) p = longint'({32'd0, xa}) * longint'({32'd0, xb});
      else    p = longint'(int'(xa)) * longint'(int'(xb));
      return p;
    end
    if (xop == 4'd5 && DIV_EN) begin
      if (xb == 0) return {xa, 32'hFFFFFFFF};
      if (xu) return {xa % xb, xa / xb};
      if (xa == 32'h80000000 && xb == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = xa;
      sb = xb;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    return cur;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [3:0] xop, input logic xu);
    @(negedge clk);
    a  = xa;
    b  = xb;
    op = xop;
    u  = xu;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(32'd34, 32'd10, OP_MULT, 1'b0);
    tick();
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_vs_mult: hi=%h lo=%h want 0/0", hi, lo);
    end
    drive(32'd34, 32'd10, OP_ADD, 1'b0);
    n_cmp++;
    if (y !== 32'd44) begin
      n_err++;
      $display("FAIL add_during_reset: got %h want %h", y, 32'd44);
    end
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_basic_ops();
    logic [3:0]  ops  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9};
    logic [31:0] want [8] = '{32'd44, 32'd24, 32'd2, 32'd42, 32'd0, 32'd34816, 32'd40, 32'd0};
    logic [31:0] wh, wl;
    for (int i = 0; i < 8; i++) begin
      drive(32'd34, 32'd10, ops[i], 1'b0);
      n_cmp++;
      if (y !== want[i]) begin
        n_err++;
        $display("FAIL basic_op%0d: got %h want %h", ops[i], y, want[i]);
      end
    end
    drive(32'd34, 32'd10, OP_DIV, 1'b0);
    n_cmp++;
    if (y !== 32'd0) begin
      n_err++;
      $display("FAIL div_result_bus: got %h want 0", y);
    end
    tick();
    wh = DIV_EN ? 32'd4 : m_hi;
    wl = DIV_EN ? 32'd3 : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++;
      $display("FAIL div_34_10: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    m_hi = wh; m_lo = wl;
    drive(32'd34, 32'd10, OP_MULT, 1'b0);
    tick();
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd340) begin
      n_err++;
      $display("FAIL mult_34_10: hi=%h lo=%h want 0/154", hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd340;
  endtask

  task automatic test_small_a();
    logic [31:0] wh, wl;
    drive(32'd10, 32'd34, OP_SUB, 1'b0);
    n_cmp++;
    if (y !== 32'hFFFFFFE8) begin n_err++; $display("FAIL sub_10_34: got %h want ffffffe8", y); end
    drive(32'd10, 32'd34, OP_SLT, 1'b0);
    n_cmp++;
    if (y !== 32'd1 || lt !== 1'b1 || eq !== 1'b0) begin
      n_err++; $display("FAIL slt_10_34: y=%h lt=%b eq=%b want 1/1/0", y, lt, eq);
    end
    drive(32'd10, 32'd34, OP_SLL, 1'b0);
    n_cmp++;
    if (y !== 32'd0) begin n_err++; $display("FAIL sll_big: got %h want 0", y); end
    drive(32'd10, 32'd34, OP_DIV, 1'b0);
    tick();
    wh = DIV_EN ? 32'd10 : m_hi;
    wl = DIV_EN ? 32'd0  : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++; $display("FAIL div_10_34: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    m_hi = wh; m_lo = wl;
  endtask

  task automatic test_negative_a();
    logic [31:0] na;
    logic [31:0] wh, wl;
    na = 32'hFFFFFAB7;
    drive(na, 32'd10, OP_ADD, 1'b0);
    n_cmp++;
    if (y !== 32'hFFFFFAC1) begin n_err++; $display("FAIL add_neg: got %h want fffffac1", y); end
    n_cmp++;
    if (lt !== 1'b1) begin n_err++; $display("FAIL lt_signed: got %b want 1", lt); end
    drive(na, 32'd10, OP_DIV, 1'b0);
    tick();
    wh = DIV_EN ? 32'hFFFFFFFD : m_hi;
    wl = DIV_EN ? 32'hFFFFFF79 : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++; $display("FAIL div_signed_neg: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    drive(na, 32'd10, OP_MULT, 1'b0);
    tick();
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFCB26) begin
      n_err++; $display("FAIL mult_signed_neg: hi=%h lo=%h want ffffffff/ffffcb26", hi, lo);
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFCB26;
    drive(na, 32'd10, OP_SLT, 1'b1);
    n_cmp++;
    if (lt !== 1'b0 || y !== 32'd0) begin
      n_err++; $display("FAIL lt_unsigned: lt=%b y=%h want 0/0", lt, y);
    end
    drive(na, 32'd10, OP_DIV, 1'b1);
    tick();
    wh = DIV_EN ? 32'd3 : m_hi;
    wl = DIV_EN ? 32'd429496594 : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++; $display("FAIL div_unsigned: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    drive(na, 32'd10, OP_MULT, 1'b1);
    tick();
    n_cmp++;
    if (hi !== 32'd9 || lo !== 32'hFFFFCB26) begin
      n_err++; $display("FAIL mult_unsigned: hi=%h lo=%h want 9/ffffcb26", hi, lo);
    end
    m_hi = 32'd9; m_lo = 32'hFFFFCB26;
    drive(na, 32'd10, OP_SRL, 1'b0);
    n_cmp++;
    if (y !== 32'h003FFFFE) begin n_err++; $display("FAIL srl: got %h want 003ffffe", y); end
    drive(na, 32'd10, OP_SRA, 1'b1);
    n_cmp++;
    if (y !== 32'h003FFFFE) begin n_err++; $display("FAIL sra_unsigned: got %h want 003ffffe", y); end
    drive(na, 32'd10, OP_SRA, 1'b0);
    n_cmp++;
    if (y !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sra_signed: got %h want fffffffe", y); end
    drive(na, 32'd40, OP_SRA, 1'b0);
    n_cmp++;
    if (y !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sra_signed_big: got %h want ffffffff", y); end
  endtask

  task automatic test_signed_mult();
    drive(32'h2978EAAB, 32'h55555555, OP_MULT, 1'b0);
    tick();
    n_cmp++;
    if (hi !== 32'h0DD2F8E3 || lo !== 32'h9CD7B1C7) begin
      n_err++; $display("FAIL mult_pos_pos: hi=%h lo=%h want 0dd2f8e3/9cd7b1c7", hi, lo);
    end
    drive(32'h2978EAAB, 32'hD5555555, OP_MULT, 1'b0);
    tick();
    n_cmp++;
    if (hi !== 32'hF916838E || lo !== 32'h1CD7B1C7) begin
      n_err++; $display("FAIL mult_pos_neg: hi=%h lo=%h want f916838e/1cd7b1c7", hi, lo);
    end
    m_hi = 32'hF916838E; m_lo = 32'h1CD7B1C7;
  endtask

  task automatic test_div_boundary();
    logic [31:0] wh, wl;
    drive(32'h12345678, 32'd0, OP_DIV, 1'b0);
    tick();
    wh = DIV_EN ? 32'h12345678 : m_hi;
    wl = DIV_EN ? 32'hFFFFFFFF : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++; $display("FAIL div_by_zero: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    m_hi = wh; m_lo = wl;
    drive(32'h80000000, 32'hFFFFFFFF, OP_DIV, 1'b0);
    tick();
    wh = DIV_EN ? 32'd0 : m_hi;
    wl = DIV_EN ? 32'h80000000 : m_lo;
    n_cmp++;
    if (hi !== wh || lo !== wl) begin
      n_err++; $display("FAIL div_min_by_m1: hi=%h lo=%h want %h/%h", hi, lo, wh, wl);
    end
    m_hi = wh; m_lo = wl;
  endtask

  task automatic test_back_to_back();
    logic [31:0] h0, l0;
    drive(32'h00010003, 32'h00020005, OP_MULT, 1'b1);
    tick();
    h0 = 32'h00000002;
    l0 = 32'h000B000F;
    n_cmp++;
    if (hi !== h0 || lo !== l0) begin
      n_err++; $display("FAIL mult_seed: hi=%h lo=%h want %h/%h", hi, lo, h0, l0);
    end
    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, (i % 2 == 0) ? 4'd0 : 4'(11 + (i % 5)), 1'b0);
      tick();
      n_cmp++;
      if (hi !== h0 || lo !== l0) begin
        n_err++; $display("FAIL hold_%0d: hi=%h lo=%h want %h/%h", i, hi, lo, h0, l0);
      end
    end
    m_hi = h0; m_lo = l0;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, wy;
    logic [3:0]  rop;
    logic        ru;
    logic [63:0] nxt;
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'($urandom_range(0, 40));
        1:       rb = ra;
        2:       rb = 32'd0;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      rop = 4'($urandom_range(0, 15));
      ru  = 1'($urandom_range(0, 1));
      drive(ra, rb, rop, ru);
      wy = ref_out(ra, rb, rop, ru);
      n_cmp++;
      if (y !== wy || eq !== (ra == rb) || lt !== ref_lt(ra, rb, ru)) begin
        n_err++;
        $display("FAIL rand_comb op=%0d a=%h b=%h u=%b: y=%h eq=%b lt=%b want %h/%b/%b",
                 rop, ra, rb, ru, y, eq, lt, wy, (ra == rb), ref_lt(ra, rb, ru));
      end
      nxt = ref_hilo(ra, rb, rop, ru, {m_hi, m_lo});
      tick();
      m_hi = nxt[63:32];
      m_lo = nxt[31:0];
      n_cmp++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_err++;
        $display("FAIL rand_hilo op=%0d a=%h b=%h u=%b: hi=%h lo=%h want %h/%h",
                 rop, ra, rb, ru, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; op = '0; u = 1'b0;
    test_reset();
    test_basic_ops();
    test_small_a();
    test_negative_a();
    test_signed_mult();
    test_div_boundary();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
